// File: rtl/tone_seq_pkg.sv
// tone_seq_pkg: shared FSM states, song entry type, tones note codes and song tables.
package tone_seq_pkg;
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
  typedef struct packed {
    logic [7:0] note;
    logic [3:0] dur;
  } song_entry_t;
  localparam logic [7:0] REST = 8'h00, NOTE_C4 = 8'h01, NOTE_D4 = 8'h02, NOTE_E4 = 8'h03,
    NOTE_F4 = 8'h04, NOTE_G4 = 8'h05, NOTE_A4 = 8'h06, NOTE_B4 = 8'h07, NOTE_C5 = 8'h08;
  localparam song_entry_t TEST_SONG [4] = '{'{NOTE_C4, 4'd2}, '{NOTE_D4, 4'd1},
    '{REST, 4'd1}, '{NOTE_F4, 4'd3}};
  localparam song_entry_t MELODY [16] = '{'{NOTE_C4, 4'd1}, '{NOTE_C4, 4'd1},
    '{NOTE_G4, 4'd1}, '{NOTE_G4, 4'd1}, '{NOTE_A4, 4'd1}, '{NOTE_A4, 4'd1},
    '{NOTE_G4, 4'd2}, '{NOTE_F4, 4'd1}, '{NOTE_F4, 4'd1}, '{NOTE_E4, 4'd1},
    '{NOTE_E4, 4'd1}, '{NOTE_D4, 4'd1}, '{NOTE_D4, 4'd1}, '{NOTE_C4, 4'd2},
    '{NOTE_C5, 4'd1}, '{REST, 4'd0}};
  // song ids 2 and 3 are the test song with a terminator at entry 1 and entry 0
  function automatic song_entry_t song_entry(input int song_id, input int idx);
    song_entry = '{REST, 4'd0};
    if (song_id == 1 && idx >= 0 && idx < 16) song_entry = MELODY[idx[3:0]];
    else if (song_id != 1 && idx >= 0 && idx < 4) begin
      song_entry = TEST_SONG[idx[1:0]];
      if ((song_id == 2 && idx == 1) || (song_id == 3 && idx == 0)) song_entry.dur = 4'd0;
    end
  endfunction
endpackage

// File: rtl/tone_song_rom.sv
// tone_song_rom: combinational song table lookup.
module tone_song_rom
  import tone_seq_pkg::*;
#(
  parameter int SONG_LEN = 16,
  parameter int SONG_ID = 1
) (
  input  logic [$clog2(SONG_LEN)-1:0] idx,
  output song_entry_t                 entry
);
  assign entry = song_entry(SONG_ID, int'(idx));
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: steps through a song table driving the tones note code.
// TONE_SEQ_GAP_EN inserts GAP_TICKS silent cycles after every note except the last before DONE.
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int TICKS_PER_BEAT = 25_000_000,
  parameter int SONG_LEN = 16,
  parameter int SONG_ID = 1
`ifdef TONE_SEQ_GAP_EN
  , parameter int GAP_TICKS = 2_500_000
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        loop,
  output logic [7:0]                  note,
  output logic [$clog2(SONG_LEN)-1:0] idx,
  output logic                        busy,
  output logic                        done
);
  localparam int IW = $clog2(SONG_LEN);
  localparam int TW = $clog2(TICKS_PER_BEAT);
  state_t state, state_d;
  logic [IW-1:0] idx_d, ld_idx;
  logic [7:0] note_d;
  logic busy_d, done_d, ld, fin, last, song_end, beat_end;
  logic [TW-1:0] tick, tick_d;
  logic [3:0] beats, beats_d;
  song_entry_t first, nxt, ld_e;
`ifdef TONE_SEQ_GAP_EN
  localparam int GW = $clog2(GAP_TICKS + 1);
  logic [GW-1:0] gcnt, gcnt_d;
`endif
  assign last = idx == IW'(SONG_LEN - 1);
  assign song_end = last || nxt.dur == 4'd0;
  assign beat_end = tick == TW'(TICKS_PER_BEAT - 1);
  tone_song_rom #(.SONG_LEN(SONG_LEN), .SONG_ID(SONG_ID)) u_first (
    .idx(IW'(0)), .entry(first));
  tone_song_rom #(.SONG_LEN(SONG_LEN), .SONG_ID(SONG_ID)) u_next (
    .idx(last ? IW'(0) : idx + 1'b1), .entry(nxt));
  always_comb begin
    state_d = state;
    idx_d = idx;
    note_d = note;
    busy_d = busy;
    tick_d = tick;
    beats_d = beats;
    ld = 1'b0;
    fin = 1'b0;
    ld_idx = song_end ? '0 : idx + 1'b1;
    ld_e = song_end ? first : nxt;
`ifdef TONE_SEQ_GAP_EN
    gcnt_d = gcnt;
`endif
    case (state)
      IDLE: begin
        ld_idx = '0;
        ld_e = first;
        ld = start && first.dur != 4'd0;
        fin = start && first.dur == 4'd0;
      end
      PLAY: begin
        tick_d = beat_end ? '0 : tick + 1'b1;
        beats_d = beats - {3'b0, beat_end};
        if (beat_end && beats == 4'd1) begin
          fin = song_end && !loop;
`ifdef TONE_SEQ_GAP_EN
          state_d = GAP;
          note_d = REST;
          gcnt_d = '0;
`else
          ld = !fin;
`endif
        end
      end
`ifdef TONE_SEQ_GAP_EN
      GAP: begin
        gcnt_d = gcnt + 1'b1;
        ld = gcnt == GW'(GAP_TICKS - 1);
      end
`endif
      default: ;
    endcase
    if (ld) begin
      state_d = PLAY;
      idx_d = ld_idx;
      note_d = ld_e.note;
      beats_d = ld_e.dur;
      tick_d = '0;
      busy_d = 1'b1;
    end
    if (fin || stop) begin
      state_d = IDLE;
      idx_d = '0;
      note_d = REST;
      busy_d = 1'b0;
      tick_d = '0;
      beats_d = '0;
    end
    done_d = fin && !stop;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      note <= REST;
      busy <= 1'b0;
      done <= 1'b0;
      tick <= '0;
      beats <= '0;
`ifdef TONE_SEQ_GAP_EN
      gcnt <= '0;
`endif
    end else begin
      state <= state_d;
      idx <= idx_d;
      note <= note_d;
      busy <= busy_d;
      done <= done_d;
      tick <= tick_d;
      beats <= beats_d;
`ifdef TONE_SEQ_GAP_EN
      gcnt <= gcnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: randomized directed bench comparing three song variants against a timeline model.
module tb_tone_sequencer;
  localparam int T = 4;
  localparam int L = 4;
`ifdef TONE_SEQ_GAP_EN
  localparam int G = 2;
`else
  localparam int G = 0;
`endif
  localparam int LEN0 = 7 * T + 4 * G;
  typedef struct {int n; int i; int b; int d;} exp_t;
  logic clk = 0, rst_n = 1, start = 0, stop = 0, loop = 0;
  logic [7:0] note [3];
  logic [1:0] idx [3];
  logic busy [3], done [3];
  int checks = 0, errors = 0;
  int sn [3][4] = '{'{1, 2, 0, 4}, '{1, 2, 0, 4}, '{1, 2, 0, 4}};
  int sd [3][4] = '{'{2, 1, 1, 3}, '{2, 0, 1, 3}, '{0, 1, 1, 3}};
  exp_t q[$];
  always #5 clk = ~clk;
  for (genvar k = 0; k < 3; k++) begin : g
    tone_sequencer #(.TICKS_PER_BEAT(T), .SONG_LEN(L), .SONG_ID(k == 0 ? 0 : k + 1)
`ifdef TONE_SEQ_GAP_EN
      , .GAP_TICKS(G)
`endif
    ) u (.clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
      .note(note[k]), .idx(idx[k]), .busy(busy[k]), .done(done[k]));
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input int k, input string tag, input exp_t e);
    chk({tag, " note"}, 32'(note[k]), e.n);
    chk({tag, " idx"}, 32'(idx[k]), e.i);
    chk({tag, " busy"}, 32'(busy[k]), e.b);
    chk({tag, " done"}, 32'(done[k]), e.d);
  endtask
  // expected per-cycle outputs after START, from the song rules alone
  task automatic build(input int k, input bit lp, input int stop_at);
    bit fin;
    q.delete();
    do begin
      for (int e = 0; e < L && sd[k][e] != 0; e++) begin
        fin = (e == L - 1) || (sd[k][e + 1] == 0);
        repeat (sd[k][e] * T) q.push_back('{sn[k][e], e, 1, 0});
        if (!fin || lp) repeat (G) q.push_back('{0, e, 1, 0});
      end
    end while (lp && q.size() > 0 && q.size() <= stop_at);
    if (stop_at > 0 && q.size() > stop_at) begin
      while (q.size() > stop_at) void'(q.pop_back());
      q.push_back('{0, 0, 0, 0});
    end else begin
      q.push_back('{0, 0, 0, 1});
      q.push_back('{0, 0, 0, 0});
    end
  endtask
  task automatic run(input int k, input bit lp, input int stop_at, input int busy_start);
    int n;
    exp_t e;
    build(k, lp, stop_at);
    n = q.size();
    stop = 1;
    @(negedge clk);
    stop = 0;
    loop = lp;
    start = 1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      e = q.pop_front();
      chk_all(k, $sformatf("s%0d l%0d c%0d", k, lp, c), e);
      stop = c == stop_at;
      start = c == busy_start;
    end
    stop = 0;
    start = 0;
    loop = 0;
  endtask
  initial begin
    int mid;
    #3 rst_n = 0;
    #1 for (int k = 0; k < 3; k++) chk_all(k, "reset", '{0, 0, 0, 0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run(0, 0, 0, $urandom_range(1, 20));
    repeat ($urandom_range(1, 5)) @(negedge clk);
    run(0, 1, 3 * LEN0 + $urandom_range(1, LEN0), $urandom_range(1, 20));
    run(0, 0, 10, 0);
    run(0, 0, $urandom_range(1, LEN0 - 1), 0);
    start = 1;
    stop = 1;
    @(negedge clk);
    start = 0;
    stop = 0;
    chk_all(0, "start+stop idle", '{0, 0, 0, 0});
    @(negedge clk);
    chk_all(0, "start+stop after", '{0, 0, 0, 0});
    run(1, 0, 0, $urandom_range(1, 6));
    run(2, 0, 0, 0);
    mid = sd[0][0] * T + G + 1;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (mid - 1) @(negedge clk);
    chk("mid note", 32'(note[0]), 2);
    rst_n = 0;
    #1 chk_all(0, "async reset", '{0, 0, 0, 0});
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk_all(0, "post reset", '{0, 0, 0, 0});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
